fsm_stim_sequencer: RTL and testbench

Self-checking controller that sequences one generated single-input/single-output FSM.
- Holds the FSM in reset, then replays a loaded bit pattern on its serial input `x`, one bit per clock.
- Captures the FSM output `y` per applied bit and compares the capture against an expected pattern.
- Reports pass/fail and the first mismatching bit index.
- Sits between the per-design test harness and the generated FSM; replaces hand-written per-bit stimulus sequences.

---
 rtl/fsm_seq_pkg.sv | 25 ++
 rtl/fsm_stim_sequencer_if.sv | 30 +++
 rtl/first_set_idx.sv | 22 ++
 rtl/fsm_stim_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_fsm_stim_sequencer.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fsm_seq_pkg.sv
// rtl/fsm_seq_pkg.sv - shared state encoding and length-mask helper for the stimulus sequencer
package fsm_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RST_DUT,
    DRIVE,
    SETTLE,
    DONE
  } seq_state_e;

  // Widest pattern the mask helper can describe; callers cast down to their own width.
  localparam int MASK_W = 64;

  // Ones in bit positions [0, n), zeros above.
  function automatic logic [MASK_W-1:0] len_mask(input int unsigned n);
    logic [MASK_W-1:0] m;
    m = '0;
    for (int i = 0; i < MASK_W; i++) begin
      m[i] = (unsigned'(i) < n);
    end
    return m;
  endfunction

endpackage

// File: rtl/fsm_stim_sequencer_if.sv
// rtl/fsm_stim_sequencer_if.sv - harness-side control/result bundle of the stimulus sequencer
interface fsm_stim_sequencer_if #(
  parameter int MAX_LEN = 32,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
);

  logic               start;
  logic               abort;
  logic [LEN_W-1:0]   len;
  logic [MAX_LEN-1:0] stim;
  logic [MAX_LEN-1:0] expect_pat;
  logic               busy;
  logic               done;
  logic               pass;
  logic [LEN_W-1:0]   mismatch_idx;
  logic [MAX_LEN-1:0] capture;

  // Harness drives the run request and reads back the result.
  modport master (
    output start, abort, len, stim, expect_pat,
    input  busy, done, pass, mismatch_idx, capture
  );

  // Sequencer consumes the run request and reports the result.
  modport slave (
    input  start, abort, len, stim, expect_pat,
    output busy, done, pass, mismatch_idx, capture
  );

endinterface

// File: rtl/first_set_idx.sv
// rtl/first_set_idx.sv - combinational priority encoder returning the lowest set bit index
module first_set_idx #(
  parameter int W     = 32,
  parameter int IDX_W = $clog2(W + 1)
) (
  input  logic [W-1:0]     vec,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx   = '0;
    valid = |vec;
    for (int i = W - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/fsm_stim_sequencer.sv
// rtl/fsm_stim_sequencer.sv - resets a serial FSM, replays a bit pattern into it and checks its output
module fsm_stim_sequencer
  import fsm_seq_pkg::*;
#(
  parameter int MAX_LEN    = 32,
  parameter int RST_CYCLES = 2,
  parameter int OUT_LAG    = 1,
  parameter int LEN_W      = $clog2(MAX_LEN + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  fsm_stim_sequencer_if.slave   bus,
  output logic                  fsm_rst,
  output logic                  fsm_x,
  input  logic                  fsm_y
);

  localparam int               RC_W    = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RC_W-1:0]  RC_LAST = RC_W'(RST_CYCLES - 1);
  localparam logic [LEN_W-1:0] MAX_L   = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] LAG_L   = LEN_W'(OUT_LAG);
  localparam logic [LEN_W-1:0] ONE_L   = LEN_W'(1);

  seq_state_e         state_q, state_d;
  logic [RC_W-1:0]    rcnt_q, rcnt_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [LEN_W-1:0]   smp_q, smp_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [MAX_LEN-1:0] stim_q, stim_d;
  logic [MAX_LEN-1:0] exp_q, exp_d;
  logic [MAX_LEN-1:0] capture_q, capture_d;
  logic               fsm_rst_q, fsm_rst_d;
  logic               fsm_x_q, fsm_x_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic [LEN_W-1:0]   mis_q, mis_d;
  logic               sample_en;

  logic [MAX_LEN-1:0] diff;
  logic [LEN_W-1:0]   fs_idx;
  logic               fs_valid;

  // Only bits inside the applied length take part in the comparison.
  assign diff = (capture_d ^ exp_q) & MAX_LEN'(len_mask(32'(len_q)));

  first_set_idx #(
    .W     (MAX_LEN),
    .IDX_W (LEN_W)
  ) u_first_set (
    .vec   (diff),
    .idx   (fs_idx),
    .valid (fs_valid)
  );

  // Run sequencing, pattern latching and per-bit capture of the FSM response.
  always_comb begin
    state_d   = state_q;
    rcnt_d    = rcnt_q;
    cnt_d     = cnt_q;
    smp_d     = smp_q;
    len_d     = len_q;
    stim_d    = stim_q;
    exp_d     = exp_q;
    capture_d = capture_q;
    sample_en = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          len_d     = (bus.len > MAX_L) ? MAX_L : bus.len;
          stim_d    = bus.stim;
          exp_d     = bus.expect_pat;
          capture_d = '0;
          rcnt_d    = '0;
          cnt_d     = '0;
          smp_d     = '0;
          state_d   = RST_DUT;
        end
      end
      RST_DUT: begin
        if (rcnt_q == RC_LAST) begin
          state_d = (len_q == '0) ? DONE : DRIVE;
        end else begin
          rcnt_d = rcnt_q + RC_W'(1);
        end
      end
      DRIVE: begin
        // Responses trail the applied bit by OUT_LAG cycles.
        sample_en = (cnt_q >= LAG_L);
        cnt_d     = cnt_q + ONE_L;
        if (cnt_q == len_q - ONE_L) begin
          state_d = (OUT_LAG == 0) ? DONE : SETTLE;
        end
      end
      SETTLE: begin
        sample_en = 1'b1;
        if (smp_q == len_q - ONE_L) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (sample_en) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        if (smp_q == LEN_W'(i)) begin
          capture_d[i] = fsm_y;
        end
      end
      smp_d = smp_q + ONE_L;
    end

    if (bus.abort) begin
      state_d = IDLE;
    end
  end

  // Registered outputs are derived from the next state so they line up with it.
  always_comb begin
    busy_d    = (state_d != IDLE);
    done_d    = (state_d == DONE);
    fsm_rst_d = !((state_d == DRIVE) || (state_d == SETTLE));
    fsm_x_d   = 1'b0;
    pass_d    = pass_q;
    mis_d     = mis_q;

    if (state_d == DRIVE) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        if (cnt_d == LEN_W'(i)) begin
          fsm_x_d = stim_d[i];
        end
      end
    end

    if (state_d == DONE) begin
      pass_d = !fs_valid;
      mis_d  = fs_valid ? fs_idx : len_q;
    end
  end

  // State, counters, latched patterns and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      rcnt_q    <= '0;
      cnt_q     <= '0;
      smp_q     <= '0;
      len_q     <= '0;
      stim_q    <= '0;
      exp_q     <= '0;
      capture_q <= '0;
      fsm_rst_q <= 1'b1;
      fsm_x_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      mis_q     <= '0;
    end else begin
      state_q   <= state_d;
      rcnt_q    <= rcnt_d;
      cnt_q     <= cnt_d;
      smp_q     <= smp_d;
      len_q     <= len_d;
      stim_q    <= stim_d;
      exp_q     <= exp_d;
      capture_q <= capture_d;
      fsm_rst_q <= fsm_rst_d;
      fsm_x_q   <= fsm_x_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      mis_q     <= mis_d;
    end
  end

  assign fsm_rst          = fsm_rst_q;
  assign fsm_x            = fsm_x_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.pass         = pass_q;
  assign bus.mismatch_idx = mis_q;
  assign bus.capture      = capture_q;

endmodule

// File: tb/tb_fsm_stim_sequencer.sv
// tb/tb_fsm_stim_sequencer.sv - self-checking bench for fsm_stim_sequencer driving a "two consecutive 1s" Moore FSM
module tb_fsm_stim_sequencer;

  localparam int MAX_LEN    = 32;
  localparam int RST_CYCLES = 2;
  localparam int OUT_LAG    = 1;
  localparam int LEN_W      = 6;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic fsm_rst, fsm_x, fsm_y;
  int   total = 0;
  int   bad = 0;
  int   ones = 0;
  logic last_pass = 1'b0;
  int   last_mis = 0;

  fsm_stim_sequencer_if #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) bus ();

  fsm_stim_sequencer #(
    .MAX_LEN    (MAX_LEN),
    .RST_CYCLES (RST_CYCLES),
    .OUT_LAG    (OUT_LAG),
    .LEN_W      (LEN_W)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .fsm_rst (fsm_rst),
    .fsm_x   (fsm_x),
    .fsm_y   (fsm_y)
  );

  always #5 clk = ~clk;

  // Controlled FSM: Moore output high once the last two applied bits were both 1.
  always @(posedge clk) begin
    if (fsm_rst) ones <= 0;
    else if (fsm_x) ones <= (ones >= 2) ? 2 : ones + 1;
    else ones <= 0;
  end
  assign fsm_y = (ones == 2);

  function automatic int clamp_len(input int l);
    return (l > MAX_LEN) ? MAX_LEN : l;
  endfunction

  function automatic logic [31:0] lmask(input int l);
    logic [31:0] m;
    for (int i = 0; i < 32; i++) m[i] = (i < l);
    return m;
  endfunction

  // Response to bit i is 1 exactly when bits i-1 and i of the stimulus are both 1.
  function automatic logic [31:0] model_capture(input int l, input logic [31:0] s);
    logic [31:0] c;
    c = '0;
    for (int i = 1; i < l; i++) c[i] = s[i] & s[i-1];
    return c;
  endfunction

  function automatic int model_first_diff(input int l, input logic [31:0] a, input logic [31:0] b);
    for (int i = 0; i < l; i++) if (a[i] != b[i]) return i;
    return l;
  endfunction

  // Cycle 1 is the first cycle after the edge that samples start.
  function automatic int model_done_cycle(input int eff);
    return (eff == 0) ? RST_CYCLES + 1 : RST_CYCLES + eff + OUT_LAG + 1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts a run and collects fsm_x while the FSM is out of reset, up to the done cycle.
  task automatic run_seq(input int l, input logic [31:0] s, input logic [31:0] e,
                         output int done_cyc, output int nlow, output logic [31:0] xs);
    bus.len = LEN_W'(l);
    bus.stim = s;
    bus.expect_pat = e;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    done_cyc = 0;
    nlow = 0;
    xs = '0;
    for (int k = 1; k <= 200 && done_cyc == 0; k++) begin
      if (!fsm_rst) begin
        if (nlow < 32) xs[nlow] = fsm_x;
        nlow++;
      end
      if (bus.done) done_cyc = k;
      else step();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    total++; if (fsm_rst !== 1'b1) begin bad++; $display("FAIL reset_fsm_rst got=%b want=1", fsm_rst); end
    total++; if (fsm_x !== 1'b0) begin bad++; $display("FAIL reset_fsm_x got=%b want=0", fsm_x); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", bus.done); end
    total++; if (bus.pass !== 1'b0) begin bad++; $display("FAIL reset_pass got=%b want=0", bus.pass); end
    total++; if (bus.mismatch_idx !== '0) begin bad++; $display("FAIL reset_mis got=%0d want=0", bus.mismatch_idx); end
    total++; if (bus.capture !== '0) begin bad++; $display("FAIL reset_capture got=%h want=0", bus.capture); end
    reset = 1'b0;
    step();
    total++; if (bus.busy !== 1'b0 || fsm_rst !== 1'b1) begin bad++; $display("FAIL idle_after_reset busy=%b fsm_rst=%b want 0/1", bus.busy, fsm_rst); end
  endtask

  task automatic test_moore_match();
    int dc, nl;
    logic [31:0] xs;
    run_seq(5, 32'b01100, 32'b01000, dc, nl, xs);
    total++; if (dc !== 9) begin bad++; $display("FAIL match_latency got=%0d want=9", dc); end
    total++; if (nl !== 6) begin bad++; $display("FAIL match_low_cycles got=%0d want=6", nl); end
    total++; if (xs !== 32'b01100) begin bad++; $display("FAIL match_x_seq got=%b want=01100", xs[5:0]); end
    total++; if (bus.capture !== 32'b01000) begin bad++; $display("FAIL match_capture got=%b want=01000", bus.capture); end
    total++; if (bus.pass !== 1'b1) begin bad++; $display("FAIL match_pass got=%b want=1", bus.pass); end
    total++; if (bus.mismatch_idx !== 6'd5) begin bad++; $display("FAIL match_mis got=%0d want=5", bus.mismatch_idx); end
    step();
    total++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin bad++; $display("FAIL match_done_pulse done=%b busy=%b want 0/0", bus.done, bus.busy); end
    total++; if (bus.pass !== 1'b1 || bus.mismatch_idx !== 6'd5) begin bad++; $display("FAIL match_hold pass=%b mis=%0d want 1/5", bus.pass, bus.mismatch_idx); end
    last_pass = 1'b1; last_mis = 5;
  endtask

  task automatic test_moore_mismatch();
    int dc, nl;
    logic [31:0] xs;
    run_seq(5, 32'b01100, 32'b00000, dc, nl, xs);
    total++; if (dc !== 9) begin bad++; $display("FAIL mismatch_latency got=%0d want=9", dc); end
    total++; if (bus.pass !== 1'b0) begin bad++; $display("FAIL mismatch_pass got=%b want=0", bus.pass); end
    total++; if (bus.mismatch_idx !== 6'd3) begin bad++; $display("FAIL mismatch_idx got=%0d want=3", bus.mismatch_idx); end
    step();
    last_pass = 1'b0; last_mis = 3;
  endtask

  task automatic test_len_zero();
    int dc, nl;
    logic [31:0] xs;
    run_seq(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, dc, nl, xs);
    total++; if (dc !== RST_CYCLES + 1) begin bad++; $display("FAIL len0_latency got=%0d want=%0d", dc, RST_CYCLES + 1); end
    total++; if (nl !== 0 || xs !== '0) begin bad++; $display("FAIL len0_no_drive low=%0d x=%h want 0/0", nl, xs); end
    total++; if (bus.pass !== 1'b1 || bus.mismatch_idx !== '0) begin bad++; $display("FAIL len0_result pass=%b mis=%0d want 1/0", bus.pass, bus.mismatch_idx); end
    total++; if (bus.capture !== '0) begin bad++; $display("FAIL len0_capture got=%h want=0", bus.capture); end
    step();
    last_pass = 1'b1; last_mis = 0;
  endtask

  task automatic test_clamp();
    int dc, nl;
    logic [31:0] xs, s, c;
    s = $urandom;
    c = model_capture(32, s);
    run_seq(40, s, c, dc, nl, xs);
    total++; if (dc !== model_done_cycle(32)) begin bad++; $display("FAIL clamp_latency got=%0d want=%0d", dc, model_done_cycle(32)); end
    total++; if (nl !== 32 + OUT_LAG) begin bad++; $display("FAIL clamp_low_cycles got=%0d want=%0d", nl, 32 + OUT_LAG); end
    total++; if (xs !== s) begin bad++; $display("FAIL clamp_x_seq got=%h want=%h", xs, s); end
    total++; if (bus.capture !== c) begin bad++; $display("FAIL clamp_capture got=%h want=%h", bus.capture, c); end
    total++; if (bus.pass !== 1'b1 || bus.mismatch_idx !== 6'd32) begin bad++; $display("FAIL clamp_result pass=%b mis=%0d want 1/32", bus.pass, bus.mismatch_idx); end
    step();
    last_pass = 1'b1; last_mis = 32;
  endtask

  task automatic test_random();
    int dc, nl, l, eff, wmis;
    logic [31:0] xs, s, c, e;
    for (int n = 0; n < 12; n++) begin
      l = $urandom_range(0, 40);
      eff = clamp_len(l);
      s = $urandom;
      c = model_capture(eff, s);
      e = c | (~lmask(eff) & $urandom);
      if (eff > 0 && $urandom_range(0, 1) == 1) e[$urandom_range(0, eff - 1)] ^= 1'b1;
      wmis = model_first_diff(eff, c, e);
      run_seq(l, s, e, dc, nl, xs);
      total++; if (dc !== model_done_cycle(eff)) begin bad++; $display("FAIL rand_latency len=%0d got=%0d want=%0d", l, dc, model_done_cycle(eff)); end
      total++; if (xs !== (s & lmask(eff))) begin bad++; $display("FAIL rand_x_seq len=%0d got=%h want=%h", l, xs, s & lmask(eff)); end
      total++; if (bus.capture !== c) begin bad++; $display("FAIL rand_capture len=%0d got=%h want=%h", l, bus.capture, c); end
      total++; if (bus.pass !== (wmis == eff)) begin bad++; $display("FAIL rand_pass len=%0d got=%b want=%b", l, bus.pass, wmis == eff); end
      total++; if (bus.mismatch_idx !== LEN_W'(wmis)) begin bad++; $display("FAIL rand_mis len=%0d got=%0d want=%0d", l, bus.mismatch_idx, wmis); end
      last_pass = (wmis == eff); last_mis = wmis;
      step();
    end
  endtask

  task automatic test_abort();
    logic [31:0] s;
    int saw;
    s = $urandom | 32'h6;
    bus.len = LEN_W'(10);
    bus.stim = s;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    step();
    // First DRIVE cycle: a fresh start request here must be ignored.
    bus.start = 1'b1; bus.len = LEN_W'(3); bus.stim = '0;
    step();
    bus.start = 1'b0;
    total++; if (fsm_rst !== 1'b0 || fsm_x !== s[1]) begin bad++; $display("FAIL abort_start_ignored fsm_rst=%b x=%b want 0/%b", fsm_rst, fsm_x, s[1]); end
    step();
    total++; if (fsm_x !== s[2]) begin bad++; $display("FAIL abort_third_bit got=%b want=%b", fsm_x, s[2]); end
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    total++; if (bus.busy !== 1'b0 || fsm_rst !== 1'b1 || fsm_x !== 1'b0 || bus.done !== 1'b0) begin bad++; $display("FAIL abort_idle busy=%b rst=%b x=%b done=%b want 0/1/0/0", bus.busy, fsm_rst, fsm_x, bus.done); end
    total++; if (bus.pass !== last_pass || bus.mismatch_idx !== LEN_W'(last_mis)) begin bad++; $display("FAIL abort_hold pass=%b mis=%0d want %b/%0d", bus.pass, bus.mismatch_idx, last_pass, last_mis); end
    saw = 0;
    for (int k = 0; k < 20; k++) begin
      if (bus.done || bus.busy) saw++;
      step();
    end
    total++; if (saw !== 0) begin bad++; $display("FAIL abort_no_done active_cycles=%0d want=0", saw); end
  endtask

  task automatic test_start_abort_idle();
    bus.len = LEN_W'(4); bus.stim = 32'hF;
    bus.start = 1'b1; bus.abort = 1'b1;
    step();
    bus.start = 1'b0; bus.abort = 1'b0;
    total++; if (bus.busy !== 1'b0 || fsm_rst !== 1'b1) begin bad++; $display("FAIL start_abort busy=%b rst=%b want 0/1", bus.busy, fsm_rst); end
    step();
    step();
    total++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin bad++; $display("FAIL start_abort_later busy=%b done=%b want 0/0", bus.busy, bus.done); end
  endtask

  task automatic test_async_reset();
    bus.len = LEN_W'(8); bus.stim = 32'hFF;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int k = 0; k < 6; k++) step();
    // Cycle 7 is the fifth DRIVE cycle; responses to bits 0..2 are captured.
    total++; if (bus.capture !== 32'h6 || bus.busy !== 1'b1) begin bad++; $display("FAIL areset_pre capture=%h busy=%b want 6/1", bus.capture, bus.busy); end
    #3;
    reset = 1'b1;
    #1;
    total++; if (fsm_rst !== 1'b1 || bus.busy !== 1'b0 || bus.capture !== '0 || fsm_x !== 1'b0) begin bad++; $display("FAIL areset_immediate rst=%b busy=%b cap=%h x=%b want 1/0/0/0", fsm_rst, bus.busy, bus.capture, fsm_x); end
    step();
    reset = 1'b0;
    step();
    total++; if (bus.busy !== 1'b0 || bus.pass !== 1'b0 || bus.mismatch_idx !== '0) begin bad++; $display("FAIL areset_after busy=%b pass=%b mis=%0d want 0/0/0", bus.busy, bus.pass, bus.mismatch_idx); end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.len = '0;
    bus.stim = '0;
    bus.expect_pat = '0;
    test_reset();
    test_moore_match();
    test_moore_mismatch();
    test_len_zero();
    test_clamp();
    test_random();
    test_abort();
    test_start_abort_idle();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
